// File: rtl/mmu_ctx_loader.sv
// -----------------------------------------------------------------------------
// mmu_ctx_loader
//
// Loads an instruction-MMU context from memory into the MMU special registers.
// When a load is requested, the block reads 16 consecutive words starting at
// base_addr. Each word is written to SR address 0x0100+idx, with the upper
// nibble of the data cleared. Instruction fetch stays stalled until the table
// is consistent again.
//
// Optional feature (compile-time macro):
//   MMU_CTX_HIGH_OFF_EN  - also fetches a 17th word (idx 16, base+16). That
//                          word goes to SR 0x0110 and keeps only its low byte.
//
// Parameters:
//   TIMEOUT_CYCLES  number of FETCH cycles (1..255) to wait for i_mem_ack.
//                   If no ack arrives in that time, the load errors out.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_req             start a load (only looked at while idle)
//   i_base_addr       word address of the context block, captured with i_req
//   o_busy            high whenever not idle
//   o_done            one-cycle pulse when a load completes successfully
//   o_err             sticky error; cleared by the next accepted request
//   o_mem_req         memory read request
//   o_mem_addr        memory read word address
//   i_mem_ack         read data valid / request accepted
//   i_mem_data        read data
//   i_mem_err         bus error, qualified by i_mem_ack
//   o_sr_we           special-register write strobe
//   o_sr_addr         special-register address
//   o_sr_data         special-register data
//   o_fetch_stall     copy of o_busy; holds instruction fetch
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for i_req
//   FETCH   | memory read of entry idx outstanding, timeout running
//   WRITE   | SR write strobe for entry idx
//   DONE    | one-cycle completion pulse
//   ERR     | one-cycle error state; o_err stays set afterwards
// -----------------------------------------------------------------------------
module mmu_ctx_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [23:0] i_base_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_mem_req,
    output logic [23:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    input  logic        i_mem_err,
    output logic        o_sr_we,
    output logic [15:0] o_sr_addr,
    output logic [15:0] o_sr_data,
    output logic        o_fetch_stall
);

`ifdef MMU_CTX_HIGH_OFF_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif

    // The timeout counter starts at 0 on FETCH entry. The FETCH cycle in which
    // the counter equals TIMEOUT_CYCLES-1 is the last one allowed.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [23:0] base;
    logic [4:0]  idx;
    logic [7:0]  tmo;

    // Entry 16 carries only the high-offset byte. Every other entry is a
    // 12-bit table field.
    function automatic logic [15:0] sr_format(input logic [4:0] i, input logic [15:0] w);
        if (i == 5'd16)
            return {8'h00, w[7:0]};
        else
            return {4'h0, w[11:0]};
    endfunction

    assign o_fetch_stall = o_busy;

    // All outputs are registered. Each transition assigns the output values
    // that belong to the state being entered. The o_sr_data register also
    // holds the word latched from memory.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            base       <= 24'h0;
            idx        <= 5'd0;
            tmo        <= 8'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= 24'h0;
            o_sr_we    <= 1'b0;
            o_sr_addr  <= 16'h0;
            o_sr_data  <= 16'h0;
        end else begin
            o_sr_we <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        base       <= i_base_addr;
                        idx        <= 5'd0;
                        tmo        <= 8'd0;
                        o_err      <= 1'b0;
                        o_busy     <= 1'b1;
                        o_mem_req  <= 1'b1;
                        o_mem_addr <= i_base_addr;
                        state      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (i_mem_err) begin
                            o_err <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            o_sr_we   <= 1'b1;
                            o_sr_addr <= 16'h0100 + 16'(idx);
                            o_sr_data <= sr_format(idx, i_mem_data);
                            state     <= S_WRITE;
                        end
                    end else if (tmo == TMO_LAST) begin
                        o_mem_req <= 1'b0;
                        o_err     <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end

                S_WRITE: begin
                    idx <= idx + 5'd1;
                    if (idx == LAST_IDX) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        tmo        <= 8'd0;
                        o_mem_req  <= 1'b1;
                        o_mem_addr <= base + 24'(idx) + 24'd1;
                        state      <= S_FETCH;
                    end
                end

                S_DONE, S_ERR: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    o_busy    <= 1'b0;
                    o_mem_req <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_ctx_loader.sv
module tb_mmu_ctx_loader;

    localparam int TO = 4;
`ifdef MMU_CTX_HIGH_OFF_EN
    localparam int N = 17;
    localparam logic [15:0] LAST_DATA = 16'h00AB;
`else
    localparam int N = 16;
    localparam logic [15:0] LAST_DATA = 16'h000F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [23:0] base_addr = 24'h0;
    logic        busy, done, err, mem_req, sr_we, fetch_stall;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        mem_err = 1'b0;
    logic [15:0] sr_addr, sr_data;

    mmu_ctx_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_base_addr(base_addr),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack), .i_mem_data(mem_data), .i_mem_err(mem_err),
        .o_sr_we(sr_we), .o_sr_addr(sr_addr), .o_sr_data(sr_data),
        .o_fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory image and response behaviour for each entry of the current load.
    logic [15:0] mem_word [17];
    int          dly      [17];
    bit          berr     [17];

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_wr[$];
    int  exp_end;
    bit  exp_ok;

    logic [15:0] last_a, last_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of a load. FETCH starts in cycle 1, counted from the
    // request cycle. An entry whose ack comes after d wait cycles occupies
    // d+1 FETCH cycles and is then followed by one write cycle. An entry that
    // waits TO cycles without an ack ends the load in ERR. So does an entry
    // whose ack carries a bus error.
    task automatic model();
        int t;
        wr_t w;
        t = 1;
        exp_wr.delete();
        for (int i = 0; i < N; i++) begin
            if (dly[i] >= TO) begin
                exp_end = t + TO;
                exp_ok  = 1'b0;
                return;
            end
            if (berr[i]) begin
                exp_end = t + dly[i] + 1;
                exp_ok  = 1'b0;
                return;
            end
            w.cyc = t + dly[i] + 1;
            w.a   = 16'h0100 + 16'(i);
            w.d   = (i == 16) ? {8'h00, mem_word[i][7:0]} : {4'h0, mem_word[i][11:0]};
            exp_wr.push_back(w);
            t = t + dly[i] + 2;
        end
        exp_end = t;
        exp_ok  = 1'b1;
    endtask

    task automatic run_load(input logic [23:0] base, input bit noisy,
                            output int nwr, output bit got_done, output int end_cyc);
        int cyc, fetch_cnt, idx;
        bit finished;
        logic [23:0] off, exp_addr;
        model();
        nwr = 0; got_done = 1'b0; end_cyc = -1; finished = 1'b0; fetch_cnt = 0;
        @(negedge clk);
        req = 1'b1; base_addr = base;
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        check("err_cleared_on_accept", 32'(err), 32'd0);
        while (!finished && cyc < 400) begin
            if (fetch_stall !== busy) check("stall_eq_busy", 32'(fetch_stall), 32'(busy));
            if (sr_we) begin
                if (nwr < exp_wr.size()) begin
                    check("wr_cycle", 32'(cyc), 32'(exp_wr[nwr].cyc));
                    check("wr_addr", 32'(sr_addr), 32'(exp_wr[nwr].a));
                    check("wr_data", 32'(sr_data), 32'(exp_wr[nwr].d));
                end else begin
                    check("extra_write", 32'(sr_addr), 32'hFFFF_FFFF);
                end
                last_a = sr_addr; last_d = sr_data;
                nwr++;
            end
            if (mem_req) begin
                exp_addr = base + 24'(nwr);
                if (mem_addr !== exp_addr) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            end
            if (done) begin
                got_done = 1'b1; end_cyc = cyc; finished = 1'b1;
            end else if (busy && err) begin
                end_cyc = cyc; finished = 1'b1;
            end
            // memory slave response for this cycle
            if (mem_req) begin
                fetch_cnt++;
                off = mem_addr - base;
                idx = int'(off);
                if (idx < N && fetch_cnt > dly[idx]) begin
                    mem_ack = 1'b1; mem_data = mem_word[idx]; mem_err = berr[idx];
                    fetch_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_data = 16'($urandom); mem_err = 1'($urandom);
                end
            end else begin
                fetch_cnt = 0;
                mem_ack  = noisy ? 1'($urandom) : 1'b0;
                mem_data = 16'($urandom);
                mem_err  = 1'($urandom);
            end
            req       = (noisy && busy && !finished) ? 1'($urandom) : 1'b0;
            base_addr = 24'($urandom);
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0; req = 1'b0;
        if (!finished) check("load_end_timeout", 32'd0, 32'd1);
        check("outcome_done", 32'(got_done), 32'(exp_ok));
        check("end_cycle", 32'(end_cyc), 32'(exp_end));
        check("write_count", 32'(nwr), 32'(exp_wr.size()));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_err_sticky", 32'(err), 32'(!exp_ok));
        check("idle_sr_we", 32'(sr_we), 32'd0);
    endtask

    typedef struct {
        logic [23:0] base;
        int          mode;      // 0 zero-wait, 1 bus error at idx 5, 2 no ack at idx 0
        int          exp_writes;
        bit          exp_done;
        int          exp_cycle;
    } vec_t;

    task automatic set_zero_wait();
        for (int i = 0; i < 17; i++) begin
            mem_word[i] = 16'hF000 + 16'(i);
            dly[i] = 0;
            berr[i] = 1'b0;
        end
        mem_word[16] = 16'h12AB;
    endtask

    initial begin
        vec_t vecs[5];
        int nwr, ecyc, cyc, wcnt;
        bit gd;

        vecs[0] = '{24'h000400, 0, N, 1'b1, 2*N+1};
        vecs[1] = '{24'hFFFFF8, 0, N, 1'b1, 2*N+1};
        vecs[2] = '{24'h000400, 1, 5, 1'b0, 12};
        vecs[3] = '{24'h123456, 2, 0, 1'b0, 5};
        vecs[4] = '{24'h000000, 0, N, 1'b1, 2*N+1};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outputs", {mem_req, sr_we, done, err, fetch_stall}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_sr", {sr_addr, sr_data}, 32'd0);
        rst = 1'b0;

        // directed table
        foreach (vecs[k]) begin
            set_zero_wait();
            if (vecs[k].mode == 1) berr[5] = 1'b1;
            if (vecs[k].mode == 2) dly[0] = 1000;
            run_load(vecs[k].base, 1'b0, nwr, gd, ecyc);
            check("vec_writes", 32'(nwr), 32'(vecs[k].exp_writes));
            check("vec_done", 32'(gd), 32'(vecs[k].exp_done));
            check("vec_cycle", 32'(ecyc), 32'(vecs[k].exp_cycle));
            if (vecs[k].mode == 0) begin
                check("vec_last_addr", 32'(last_a), 32'(16'h0100 + 16'(N - 1)));
                check("vec_last_data", 32'(last_d), 32'(LAST_DATA));
            end
        end

        // reset after the third write
        set_zero_wait();
        @(negedge clk);
        req = 1'b1; base_addr = 24'h000200;
        @(negedge clk);
        req = 1'b0;
        wcnt = 0;
        for (cyc = 1; cyc < 40 && !rst; cyc++) begin
            if (sr_we) wcnt++;
            if (wcnt == 3) begin
                rst = 1'b1; mem_ack = 1'b0;
            end else begin
                mem_ack = mem_req; mem_data = mem_word[wcnt]; mem_err = 1'b0;
            end
            @(negedge clk);
        end
        check("rst_mid_reached", 32'(rst), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_outs", {mem_req, sr_we, done, err}, 32'd0);
        rst = 1'b0;
        wcnt = 0;
        repeat (10) begin
            if (sr_we) wcnt++;
            @(negedge clk);
        end
        check("no_write_after_rst", 32'(wcnt), 32'd0);
        run_load(24'h000300, 1'b0, nwr, gd, ecyc);
        check("after_rst_done", 32'(gd), 32'd1);

        // randomized loads with spurious acks and requests
        for (int r = 0; r < 40; r++) begin
            logic [23:0] b;
            for (int i = 0; i < 17; i++) begin
                mem_word[i] = 16'($urandom);
                dly[i] = ($urandom % 20 == 0) ? TO + int'($urandom % 3) : int'($urandom % 3);
                berr[i] = ($urandom % 30 == 0);
            end
            b = ($urandom % 4 == 0) ? 24'hFFFFF0 + 24'($urandom % 16) : 24'($urandom);
            run_load(b, 1'b1, nwr, gd, ecyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmu_ctx_loader.md
MMU_CTX_LOADER -- requirements
Module: mmu_ctx_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles to wait for i_mem_ack per fetch (8-bit, 1..255).
REQ-002 Ports SHALL be:
- i_clk  in  1  clock; reset i_rst, synchronous, active-high
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  start context load; sampled only in IDLE
- i_base_addr  in  24  word address of context block; sampled with i_req
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  sticky error flag
- o_mem_req  out  1  memory read request
- o_mem_addr  out  24  memory read word address
- i_mem_ack  in  1  read data valid / request accepted
- i_mem_data  in  16  read data
- i_mem_err  in  1  bus error, qualified by i_mem_ack
- o_sr_we  out  1  special-register write strobe into the instruction MMU
- o_sr_addr  out  16  special-register address
- o_sr_data  out  16  special-register data
- o_fetch_stall  out  1  equals o_busy; holds instruction fetch while the table is inconsistent

Function
REQ-003 FSM states SHALL be IDLE, FETCH, WRITE, DONE, ERR.
REQ-004 IDLE: i_req=1 latches i_base_addr, clears idx to 0, clears o_err, and enters FETCH next cycle.
REQ-005 FETCH: o_mem_req=1, o_mem_addr=(base+idx) mod 2^24; on i_mem_ack=1 & i_mem_err=0, latch i_mem_data and go to WRITE.
REQ-006 FETCH: on i_mem_ack=1 & i_mem_err=1, go to ERR; no SR write for that index.
REQ-007 FETCH: timeout counter clears on FETCH entry; when it reaches TIMEOUT_CYCLES without ack, go to ERR.
REQ-008 WRITE: o_sr_we=1 for exactly one cycle; for idx 0..15, o_sr_addr=16'h0100+idx and o_sr_data={4'h0, latched[11:0]}.
REQ-009 After WRITE, idx increments; if idx was the last index, go to DONE, else go to FETCH.
REQ-010 DONE: o_done=1 for one cycle, then IDLE.
REQ-011 ERR: o_err=1 (held through IDLE until next accepted i_req); next state IDLE after one cycle.
REQ-012 i_req while o_busy=1 SHALL be ignored (not queued).
REQ-013 o_mem_req, o_sr_we, and o_done SHALL be 0 in any state that does not drive them.
REQ-014 Min latency with zero-wait ack: 2 cycles per entry; o_done asserts the cycle after the final write (16 entries: 33 cycles from i_req).
REQ-015 i_mem_ack outside FETCH SHALL be ignored.

Reset
REQ-016 i_rst SHALL force IDLE, idx=0, timeout=0, base=0, and latched data=0; all outputs 0.
REQ-017 Reset mid-load SHALL abort with no further SR writes; entries already written remain in the MMU.

Configuration
REQ-018 Macro MMU_CTX_HIGH_OFF_EN defined: a 17th word (idx 16, address base+16) SHALL be fetched and written with o_sr_addr=16'h0110 and o_sr_data={8'h00, latched[7:0]}; last index=16, so the 16-entry latency becomes 35 cycles.
REQ-019 Macro MMU_CTX_HIGH_OFF_EN undefined: last index=15 and address 16'h0110 is never written.

Verification
REQ-020 Base=24'h000400, zero-wait ack, data=16'hF000+idx -> 16 writes at 0x100..0x10F with data 0x000..0x00F; o_done in cycle 33; o_err=0.
REQ-021 Base=24'hFFFFF8 -> o_mem_addr wraps through 24'hFFFFFF to 24'h000007; all 16 writes occur.
REQ-022 i_mem_err with ack at idx 5 -> writes to 0x100..0x104 only; o_err=1, no o_done; next i_req clears o_err.
REQ-023 TIMEOUT_CYCLES=4 and no ack at idx 0 -> ERR after 4 FETCH cycles; o_sr_we never asserted.
REQ-024 i_rst asserted after the 3rd write -> next cycle o_busy=0 and no more writes; a fresh i_req completes normally.
REQ-025 With MMU_CTX_HIGH_OFF_EN and word 16 = 16'h12AB -> final write is o_sr_addr=0x110 with data 0x00AB, and o_done in cycle 35.
